// File: rtl/bus_arbiter_ctrl_pkg.sv
// Shared definitions for the 2-master / 4-slave bus controller:
// FSM state encoding, slave index codes and the address-map nibbles.
package bus_arbiter_ctrl_pkg;

  // Bus ownership states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWN_M0 = 2'd1,
    ST_OWN_M1 = 2'd2
  } state_e;

  // Slave index of an outstanding read; SLV_NONE means no read in flight
  typedef enum logic [2:0] {
    SLV_S0   = 3'd0,
    SLV_S1   = 3'd1,
    SLV_S2   = 3'd2,
    SLV_S3   = 3'd3,
    SLV_NONE = 3'd4
  } slv_e;

  // Address-map nibbles (address bits [7:4]) for each slave
  localparam logic [3:0] MAP_S0 = 4'h0;
  localparam logic [3:0] MAP_S1 = 4'h1;
  localparam logic [3:0] MAP_S2 = 4'h2;
  localparam logic [3:0] MAP_S3 = 4'h3;

  // One-hot select to slave index; anything not exactly one-hot maps to NONE
  function automatic slv_e sel_to_slv(input logic [3:0] sel);
    slv_e idx;
    case (sel)
      4'b0001: idx = SLV_S0;
      4'b0010: idx = SLV_S1;
      4'b0100: idx = SLV_S2;
      4'b1000: idx = SLV_S3;
      default: idx = SLV_NONE;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/bus_arbiter_ctrl_decoder.sv
// Slave address decoder: maps the region nibble of the bus address to a
// one-hot slave select, or flags the access as unmapped. Purely combinational.
module bus_addr_decoder
  import bus_arbiter_ctrl_pkg::*;
(
  input  logic [3:0] region_i,   // address bits [7:4]
  input  logic       en_i,       // owner is actively requesting
  output logic [3:0] sel_o,
  output logic       unmapped_o
);

  // Decode region nibble; nothing is selected unless enabled
  always_comb begin
    sel_o      = 4'b0000;
    unmapped_o = 1'b0;
    if (en_i) begin
      case (region_i)
        MAP_S0:  sel_o = 4'b0001;
        MAP_S1:  sel_o = 4'b0010;
        MAP_S2:  sel_o = 4'b0100;
        MAP_S3:  sel_o = 4'b1000;
        default: unmapped_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/bus_arbiter_ctrl.sv
// Shared-bus controller: arbitrates host (M0) and DMAC (M1) with registered
// grants and a starvation guard, routes the owner's request to one of four
// slaves and returns synchronous-RAM read data one cycle after the access.
module bus_arbiter_ctrl
  import bus_arbiter_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              M0_req,
  input  logic              M0_wr,
  input  logic [ADDR_W-1:0] M0_address,
  input  logic [DATA_W-1:0] M0_dout,
  input  logic              M1_req,
  input  logic              M1_wr,
  input  logic [ADDR_W-1:0] M1_address,
  input  logic [DATA_W-1:0] M1_dout,
  input  logic [DATA_W-1:0] S0_dout,
  input  logic [DATA_W-1:0] S1_dout,
  input  logic [DATA_W-1:0] S2_dout,
  input  logic [DATA_W-1:0] S3_dout,
  output logic              M0_grant,
  output logic              M1_grant,
  output logic              S0_sel,
  output logic              S1_sel,
  output logic              S2_sel,
  output logic              S3_sel,
  output logic              S_wr,
  output logic [ADDR_W-1:0] S_address,
  output logic [DATA_W-1:0] S_din,
  output logic [DATA_W-1:0] M_din,
  output logic              decode_err
);

  // Last hold count before the waiting master must be given the bus
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  slv_e                rd_slv_q, rd_slv_d;
  logic                decode_err_q, decode_err_d;

  logic                own_req;
  logic                other_req;
  logic                s_wr;
  logic [ADDR_W-1:0]   s_addr;
  logic [DATA_W-1:0]   s_din;
  logic [3:0]          sel;
  logic                unmapped;

  // Request of the current owner and of the master waiting behind it
  always_comb begin
    own_req   = 1'b0;
    other_req = 1'b0;
    case (state_q)
      ST_OWN_M0: begin
        own_req   = M0_req;
        other_req = M1_req;
      end
      ST_OWN_M1: begin
        own_req   = M1_req;
        other_req = M0_req;
      end
      default: begin
        own_req   = 1'b0;
        other_req = 1'b0;
      end
    endcase
  end

  // Arbitration: M0 wins ties from idle, direct handover on release,
  // forced handover once the owner has held the bus MAX_HOLD cycles under contention
  always_comb begin
    state_d = state_q;
    hold_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (M0_req)      state_d = ST_OWN_M0;
        else if (M1_req) state_d = ST_OWN_M1;
      end
      ST_OWN_M0: begin
        if (!M0_req)                            state_d = M1_req ? ST_OWN_M1 : ST_IDLE;
        else if (M1_req && hold_q == HOLD_LAST) state_d = ST_OWN_M1;
      end
      ST_OWN_M1: begin
        if (!M1_req)                            state_d = M0_req ? ST_OWN_M0 : ST_IDLE;
        else if (M0_req && hold_q == HOLD_LAST) state_d = ST_OWN_M0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Count only while the same owner keeps the bus with someone waiting
    if ((state_q != ST_IDLE) && (state_d == state_q) && other_req) begin
      hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + HOLD_W'(1);
    end
  end

  // Master mux: idle bus drives zeros; write strobe only while owner requests
  always_comb begin
    s_wr   = 1'b0;
    s_addr = '0;
    s_din  = '0;
    case (state_q)
      ST_OWN_M0: begin
        s_wr   = M0_wr & M0_req;
        s_addr = M0_address;
        s_din  = M0_dout;
      end
      ST_OWN_M1: begin
        s_wr   = M1_wr & M1_req;
        s_addr = M1_address;
        s_din  = M1_dout;
      end
      default: begin
        s_wr   = 1'b0;
        s_addr = '0;
        s_din  = '0;
      end
    endcase
  end

  bus_addr_decoder u_decoder (
    .region_i   (s_addr[ADDR_W-1 -: 4]),
    .en_i       (own_req),
    .sel_o      (sel),
    .unmapped_o (unmapped)
  );

  // Remember which slave will present read data on the next cycle
  always_comb begin
    rd_slv_d     = ((|sel) && !s_wr) ? sel_to_slv(sel) : SLV_NONE;
    decode_err_d = unmapped;
  end

  // State, hold counter, pending-read slave and error pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      rd_slv_q     <= SLV_NONE;
      decode_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      rd_slv_q     <= rd_slv_d;
      decode_err_q <= decode_err_d;
    end
  end

  // Read-data return from the slave addressed on the previous cycle
  always_comb begin
    M_din = '0;
    case (rd_slv_q)
      SLV_S0:  M_din = S0_dout;
      SLV_S1:  M_din = S1_dout;
      SLV_S2:  M_din = S2_dout;
      SLV_S3:  M_din = S3_dout;
      default: M_din = '0;
    endcase
  end

  assign M0_grant   = (state_q == ST_OWN_M0);
  assign M1_grant   = (state_q == ST_OWN_M1);
  assign S0_sel     = sel[0];
  assign S1_sel     = sel[1];
  assign S2_sel     = sel[2];
  assign S3_sel     = sel[3];
  assign S_wr       = s_wr;
  assign S_address  = s_addr;
  assign S_din      = s_din;
  assign decode_err = decode_err_q;

endmodule
